// File: rtl/tmon_pkg.sv
// Shared types for the temperature-monitor bus arbiter: opcodes and FSM states.
// TMON_ARB_TIMEOUT_EN adds the ABORT state used by the ISSUE timeout.
package tmon_pkg;

    localparam int TMON_DATA_W = 8;
    localparam int TMON_TMO_W  = 8;

    typedef enum logic [1:0] {
        NOOP          = 2'd0,
        RESET         = 2'd1,
        SET_FRQ       = 2'd2,
        SET_HIGH_TEMP = 2'd3
    } tmon_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
`ifdef TMON_ARB_TIMEOUT_EN
        ,
        ST_ABORT = 2'd3
`endif
    } tmon_state_t;

endpackage

// File: rtl/tmon_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_grant+1,
// ascending with wrap.
module tmon_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last_grant,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    logic [IDXW-1:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = IDXW'((int'(i_last_grant) + k) % NREQ);
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmon_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one monitor bus.
// Define TMON_ARB_TIMEOUT_EN to abort ISSUE after TMO_CYC cycles (req_err pulse).
module tmon_arbiter
    import tmon_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    input  tmon_op_t [NREQ-1:0]              req_op,
    input  logic [NREQ-1:0][TMON_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]                  req_ready,
    output logic [NREQ-1:0]                  req_done,
`ifdef TMON_ARB_TIMEOUT_EN
    output logic [NREQ-1:0]                  req_err,
`endif
    output logic                             mon_valid,
    output tmon_op_t                         mon_op,
    output logic [TMON_DATA_W-1:0]           mon_opnd,
    input  logic                             mon_ready,
    output logic                             busy
);

    localparam int IDXW = $clog2(NREQ);

    tmon_state_t            r_state;
    tmon_state_t            w_state_next;
    logic [IDXW-1:0]        r_last_grant;
    logic [IDXW-1:0]        r_idx;
    tmon_op_t               r_op;
    logic [TMON_DATA_W-1:0] r_data;

    logic [NREQ-1:0]        w_grant;
    logic [IDXW-1:0]        w_win_idx;
    logic                   w_any;
    logic                   w_accept;

    tmon_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_idx        (w_win_idx),
        .o_any        (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDXW'(NREQ - 1);
            r_idx        <= '0;
            r_op         <= NOOP;
            r_data       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_win_idx;
                r_idx        <= w_win_idx;
                r_op         <= req_op[w_win_idx];
                r_data       <= req_data[w_win_idx];
            end
        end
    end

`ifdef TMON_ARB_TIMEOUT_EN
    logic [TMON_TMO_W-1:0] r_tmo_cnt;

    // Cleared on every accept, i.e. on entry to ISSUE; counts stalled ISSUE cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE && !mon_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = '0;
        req_done     = '0;
`ifdef TMON_ARB_TIMEOUT_EN
        req_err      = '0;
`endif
        mon_valid    = 1'b0;
        mon_op       = NOOP;
        mon_opnd     = '0;
        busy         = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready    = w_grant;
                    w_accept     = 1'b1;
                    w_state_next = (req_op[w_win_idx] == NOOP) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mon_valid = 1'b1;
                mon_op    = r_op;
                mon_opnd  = r_data;
                // A handshake takes priority over a timeout in the same cycle.
                if (mon_ready) begin
                    w_state_next = ST_DONE;
                end
`ifdef TMON_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TMON_TMO_W'(TMO_CYC)) begin
                    w_state_next = ST_ABORT;
                end
`endif
            end
            ST_DONE: begin
                req_done[r_idx] = 1'b1;
                w_state_next    = ST_IDLE;
            end
`ifdef TMON_ARB_TIMEOUT_EN
            ST_ABORT: begin
                req_err[r_idx] = 1'b1;
                w_state_next   = ST_IDLE;
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet for the whole time reset is held.
        if (reset) begin
            w_accept  = 1'b0;
            req_ready = '0;
            req_done  = '0;
`ifdef TMON_ARB_TIMEOUT_EN
            req_err   = '0;
`endif
            mon_valid = 1'b0;
            mon_op    = NOOP;
            mon_opnd  = '0;
            busy      = 1'b0;
        end
    end

endmodule
